cmd_stream_arb: RTL

Round-robin arbiter that shares the single outbound command stream between up to eight command generators, such as the `out_cmd` task handler and its sibling handlers. It grants one source at a time. The grant is held for a whole command, delimited by `last`, so words from different commands never interleave. Each accepted word passes through a one-entry output register. A watchdog releases a grant whose command stalls mid-transfer and reports the offending source.

---
 rtl/cmd_icd_pkg.sv | 24 ++
 rtl/rr_grant.sv | 29 ++
 rtl/cmd_stream_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/cmd_icd_pkg.sv
// Shared types for the command-stream path: arbiter states, the output word
// layout and the round-robin pointer increment.
package cmd_icd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int CMD_ARB_MAX_SRC = 8;
  localparam int CMD_W           = 32;

  typedef struct packed {
    logic             last;
    logic [CMD_W-1:0] data;
  } cmd_word_t;

  // Explicit wrap so non-power-of-2 source counts stay in range.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Kept standalone so the response path can reuse it.
module rr_grant #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] grant
);

  logic [W-1:0] idx;

  // Walk the rotated order backwards so the nearest requester is written last.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/cmd_stream_arb.sv
// Command-granular round-robin arbiter onto one outbound stream, with a
// one-entry output register and a stall watchdog that drops a hung grant.
module cmd_stream_arb
  import cmd_icd_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int TIMEOUT = 100000,
  localparam int IDW     = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    asi_cmd_valid,
  input  logic [NUM_SRC*32-1:0] asi_cmd_data,
  input  logic [NUM_SRC-1:0]    asi_cmd_last,
  output logic [NUM_SRC-1:0]    asi_cmd_ready,
  output logic                  aso_cmd_valid,
  output logic [31:0]           aso_cmd_data,
  output logic                  aso_cmd_last,
  input  logic                  aso_cmd_ready,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  err_valid,
  output logic [IDW-1:0]        err_src
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  arb_state_t                  state, state_nxt;
  logic [IDW-1:0]              ptr, rr_gnt;
  logic                        rr_any;
  logic [NUM_SRC-1:0][31:0]    src_data;
  logic [31:0]                 wd_cnt;
  cmd_word_t                   out_q;
  logic                        out_room, src_acc, out_acc, progress, wd_fire, grant_load;

  assign src_data     = asi_cmd_data;
  assign aso_cmd_data = out_q.data;
  assign aso_cmd_last = out_q.last;

  rr_grant #(.N(NUM_SRC)) u_rr (
    .req   (asi_cmd_valid),
    .ptr   (ptr),
    .any   (rr_any),
    .grant (rr_gnt)
  );

  assign busy     = (state == XFER) || (state == DRAIN);
  assign out_room = !aso_cmd_valid || aso_cmd_ready;
  assign out_acc  = aso_cmd_valid && aso_cmd_ready;
  assign src_acc  = (state == XFER) && asi_cmd_valid[grant_id] && out_room;
  assign progress = src_acc || out_acc;
  assign wd_fire  = busy && !progress && (wd_cnt == WD_LAST);

  // Ready is the only combinational output: it follows downstream ready directly.
  always_comb begin
    asi_cmd_ready = '0;
    if (state == XFER) asi_cmd_ready[grant_id] = out_room;
  end

  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    case (state)
      IDLE: begin
        if (rr_any) begin
          grant_load = 1'b1;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        if (wd_fire) state_nxt = IDLE;
        else if (src_acc && asi_cmd_last[grant_id]) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (wd_fire || out_acc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_id      <= '0;
      out_q         <= '0;
      aso_cmd_valid <= 1'b0;
      wd_cnt        <= '0;
      err_valid     <= 1'b0;
      err_src       <= '0;
    end else begin
      state     <= state_nxt;
      err_valid <= wd_fire;
      if (wd_fire) err_src <= grant_id;
      if (grant_load) begin
        grant_id <= rr_gnt;
        ptr      <= IDW'(rr_next(int'(rr_gnt), NUM_SRC));
      end
      if (grant_load || progress) wd_cnt <= '0;
      else if (busy)              wd_cnt <= wd_cnt + 32'd1;
      // An abort discards whatever is parked in the output register.
      if (wd_fire) aso_cmd_valid <= 1'b0;
      else if (src_acc) begin
        aso_cmd_valid <= 1'b1;
        out_q         <= '{last: asi_cmd_last[grant_id], data: src_data[grant_id]};
      end else if (out_acc) aso_cmd_valid <= 1'b0;
    end
  end

endmodule
